// File: rtl/ni_packetizer_pkg.sv
// Shared network definitions: flit format, flit types, router ports and field widths.
package ni_packetizer_pkg;

  localparam int unsigned VC_PER_PORT    = 2;
  localparam int unsigned VC_PER_PORT_W  = 1;
  localparam int unsigned X_W            = 2;
  localparam int unsigned Y_W            = 2;
  localparam int unsigned FLIT_PAYLOAD_W = 16;

  typedef enum logic [1:0] {
    FlitHeader = 2'd0,
    FlitBody   = 2'd1,
    FlitTail   = 2'd2,
    FlitHt     = 2'd3
  } flit_type_t;

  // North is the direction of increasing Y, East of increasing X.
  typedef enum logic [2:0] {
    PortLocal = 3'd0,
    PortNorth = 3'd1,
    PortEast  = 3'd2,
    PortSouth = 3'd3,
    PortWest  = 3'd4
  } port_t;

  typedef struct packed {
    flit_type_t                  ftype;
    logic [VC_PER_PORT_W-1:0]    vc;
    logic [X_W-1:0]              dest_x;
    logic [Y_W-1:0]              dest_y;
    port_t                       next_hop_port;
    logic [FLIT_PAYLOAD_W-1:0]   payload;
  } flit_t;

endpackage

// File: rtl/ni_xy_route.sv
// XY dimension-ordered routing for the local router: resolve X first, then Y, else Local.
module ni_xy_route
  import ni_packetizer_pkg::*;
#(
  parameter int unsigned MY_X_ADDR = 2,
  parameter int unsigned MY_Y_ADDR = 1
) (
  input  logic [X_W-1:0] dest_x_i,
  input  logic [Y_W-1:0] dest_y_i,
  output port_t          port_o
);

  localparam logic [X_W-1:0] MyX = X_W'(MY_X_ADDR);
  localparam logic [Y_W-1:0] MyY = Y_W'(MY_Y_ADDR);

  always_comb begin
    port_o = PortLocal;
    if (dest_x_i > MyX) begin
      port_o = PortEast;
    end else if (dest_x_i < MyX) begin
      port_o = PortWest;
    end else if (dest_y_i > MyY) begin
      port_o = PortNorth;
    end else if (dest_y_i < MyY) begin
      port_o = PortSouth;
    end
  end

endmodule

// File: rtl/ni_packetizer.sv
// Network-interface injector: latches a whole packet and streams it as flits into the
// router local port, stalling on the packet's VC on/off backpressure.
module ni_packetizer
  import ni_packetizer_pkg::*;
#(
  parameter int unsigned MY_X_ADDR = 2,
  parameter int unsigned MY_Y_ADDR = 1,
  parameter int unsigned MAX_FLITS = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                pkt_valid,
  output logic                                pkt_ready,
  input  logic [VC_PER_PORT_W-1:0]            pkt_vc,
  input  logic [X_W-1:0]                      pkt_dest_x,
  input  logic [Y_W-1:0]                      pkt_dest_y,
  input  logic [$clog2(MAX_FLITS+1)-1:0]      pkt_len,
  input  logic [MAX_FLITS*FLIT_PAYLOAD_W-1:0] pkt_data,
  input  logic [VC_PER_PORT-1:0]              on_off_in,
  output logic                                wr_en_out,
  output flit_t                               flit_out
);

  localparam int unsigned LEN_W  = $clog2(MAX_FLITS + 1);
  localparam int unsigned DATA_W = MAX_FLITS * FLIT_PAYLOAD_W;
  localparam logic [LEN_W-1:0] LenOne = LEN_W'(1);
  localparam logic [LEN_W-1:0] LenMax = LEN_W'(MAX_FLITS);

  typedef enum logic {StIdle, StSend} state_e;

  state_e                   state_q, state_d;
  logic [LEN_W-1:0]         cnt_q, cnt_d;
  logic [LEN_W-1:0]         len_q, len_d;
  logic [VC_PER_PORT_W-1:0] vc_q, vc_d;
  logic [X_W-1:0]           dest_x_q, dest_x_d;
  logic [Y_W-1:0]           dest_y_q, dest_y_d;
  logic [DATA_W-1:0]        data_q, data_d;
  logic                     wr_en_q, wr_en_d;
  flit_t                    flit_q, flit_d;

  port_t      route;
  flit_type_t ftype;

  ni_xy_route #(
    .MY_X_ADDR(MY_X_ADDR),
    .MY_Y_ADDR(MY_Y_ADDR)
  ) u_route (
    .dest_x_i(dest_x_q),
    .dest_y_i(dest_y_q),
    .port_o  (route)
  );

  assign pkt_ready = (state_q == StIdle) && !reset;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    vc_d     = vc_q;
    dest_x_d = dest_x_q;
    dest_y_d = dest_y_q;
    data_d   = data_q;
    wr_en_d  = 1'b0;
    flit_d   = flit_q;
    ftype    = FlitBody;

    unique case (state_q)
      StIdle: begin
        if (pkt_valid && pkt_ready) begin
          len_d    = pkt_len;
          vc_d     = pkt_vc;
          dest_x_d = pkt_dest_x;
          dest_y_d = pkt_dest_y;
          data_d   = pkt_data;
          cnt_d    = '0;
          state_d  = StSend;
        end
      end
      StSend: begin
        // Only the latched VC's backpressure bit matters.
        if (!on_off_in[vc_q]) begin
          if (len_q == LenOne) begin
            ftype = FlitHt;
          end else if (cnt_q == '0) begin
            ftype = FlitHeader;
          end else if (cnt_q == len_q - LenOne) begin
            ftype = FlitTail;
          end else begin
            ftype = FlitBody;
          end
          wr_en_d              = 1'b1;
          flit_d.ftype         = ftype;
          flit_d.vc            = vc_q;
          flit_d.dest_x        = dest_x_q;
          flit_d.dest_y        = dest_y_q;
          flit_d.next_hop_port = (ftype == FlitHeader || ftype == FlitHt) ? route : PortLocal;
          flit_d.payload       = data_q[FLIT_PAYLOAD_W*int'(cnt_q) +: FLIT_PAYLOAD_W];
          cnt_d                = cnt_q + LenOne;
          if (cnt_q == len_q - LenOne) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      len_q    <= '0;
      vc_q     <= '0;
      dest_x_q <= '0;
      dest_y_q <= '0;
      data_q   <= '0;
      wr_en_q  <= 1'b0;
      flit_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      vc_q     <= vc_d;
      dest_x_q <= dest_x_d;
      dest_y_q <= dest_y_d;
      data_q   <= data_d;
      wr_en_q  <= wr_en_d;
      flit_q   <= flit_d;
    end
  end

  assign wr_en_out = wr_en_q;
  assign flit_out  = flit_q;

  // A zero or oversized length must never be accepted.
  assert property (@(posedge clk) disable iff (reset)
    (pkt_valid && pkt_ready) |-> (pkt_len != '0 && pkt_len <= LenMax));

endmodule

// File: tb/tb_ni_packetizer.sv
// Bench for ni_packetizer: directed scenarios plus random traffic, all checked against a
// packet-level model that expands each accepted packet into its expected flit list.
module tb_ni_packetizer;
  import ni_packetizer_pkg::*;

  localparam int unsigned MX = 2;
  localparam int unsigned MY = 1;
  localparam int unsigned MF = 4;
  localparam int unsigned LW = $clog2(MF + 1);

  logic                          clk = 1'b0;
  logic                          reset;
  logic                          pkt_valid;
  logic                          pkt_ready;
  logic [VC_PER_PORT_W-1:0]      pkt_vc;
  logic [X_W-1:0]                pkt_dest_x;
  logic [Y_W-1:0]                pkt_dest_y;
  logic [LW-1:0]                 pkt_len;
  logic [MF*FLIT_PAYLOAD_W-1:0]  pkt_data;
  logic [VC_PER_PORT-1:0]        on_off_in;
  logic                          wr_en_out;
  flit_t                         flit_out;

  ni_packetizer #(
    .MY_X_ADDR(MX),
    .MY_Y_ADDR(MY),
    .MAX_FLITS(MF)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pkt_valid (pkt_valid),
    .pkt_ready (pkt_ready),
    .pkt_vc    (pkt_vc),
    .pkt_dest_x(pkt_dest_x),
    .pkt_dest_y(pkt_dest_y),
    .pkt_len   (pkt_len),
    .pkt_data  (pkt_data),
    .on_off_in (on_off_in),
    .wr_en_out (wr_en_out),
    .flit_out  (flit_out)
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Model: flits still owed for the current packet, and the predicted output registers.
  flit_t pend[$];
  bit    mdl_wr;
  flit_t mdl_flit;

  task automatic check_eq(string tag, logic [63:0] obs, logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_flit(flit_t o, flit_t e);
    check_eq("flit_type", 64'(o.ftype), 64'(e.ftype));
    check_eq("flit_vc", 64'(o.vc), 64'(e.vc));
    check_eq("flit_dest_x", 64'(o.dest_x), 64'(e.dest_x));
    check_eq("flit_dest_y", 64'(o.dest_y), 64'(e.dest_y));
    check_eq("flit_payload", 64'(o.payload), 64'(e.payload));
    if (e.ftype == FlitHeader || e.ftype == FlitHt)
      check_eq("next_hop_port", 64'(o.next_hop_port), 64'(e.next_hop_port));
  endtask

  function automatic port_t mdl_route(int dx, int dy);
    if (dx > int'(MX)) return PortEast;
    if (dx < int'(MX)) return PortWest;
    if (dy > int'(MY)) return PortNorth;
    if (dy < int'(MY)) return PortSouth;
    return PortLocal;
  endfunction

  task automatic mdl_accept(int vc, int dx, int dy, int len, logic [63:0] data);
    for (int i = 0; i < len; i++) begin
      flit_t f;
      f        = '0;
      f.vc     = VC_PER_PORT_W'(vc);
      f.dest_x = X_W'(dx);
      f.dest_y = Y_W'(dy);
      f.payload = data[16*i +: 16];
      if (len == 1)          f.ftype = FlitHt;
      else if (i == 0)       f.ftype = FlitHeader;
      else if (i == len - 1) f.ftype = FlitTail;
      else                   f.ftype = FlitBody;
      if (f.ftype == FlitHeader || f.ftype == FlitHt) f.next_hop_port = mdl_route(dx, dy);
      pend.push_back(f);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic step(bit rst, bit v, int vc, int dx, int dy, int len, logic [63:0] data,
                      logic [1:0] oo);
    @(negedge clk);
    reset      = rst;
    pkt_valid  = v;
    pkt_vc     = VC_PER_PORT_W'(vc);
    pkt_dest_x = X_W'(dx);
    pkt_dest_y = Y_W'(dy);
    pkt_len    = LW'(len);
    pkt_data   = data;
    on_off_in  = oo;
    #1;
    check_eq("pkt_ready", 64'(pkt_ready), 64'(!rst && pend.size() == 0));
    check_eq("wr_en_out", 64'(wr_en_out), 64'(mdl_wr));
    check_flit(flit_out, mdl_flit);
    if (rst) begin
      pend.delete();
      mdl_wr   = 1'b0;
      mdl_flit = '0;
    end else if (pend.size() == 0) begin
      mdl_wr = 1'b0;
      if (v) mdl_accept(vc, dx, dy, len, data);
    end else if (!oo[pend[0].vc]) begin
      mdl_wr   = 1'b1;
      mdl_flit = pend.pop_front();
    end else begin
      mdl_wr = 1'b0;
    end
  endtask

  task automatic idle(int n, logic [1:0] oo);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, 0, 1, 64'h0, oo);
  endtask

  initial begin
    mdl_wr     = 1'b0;
    mdl_flit   = '0;
    reset      = 1'b1;
    pkt_valid  = 1'b0;
    pkt_vc     = '0;
    pkt_dest_x = '0;
    pkt_dest_y = '0;
    pkt_len    = LW'(1);
    pkt_data   = '0;
    on_off_in  = '0;
    repeat (2) @(posedge clk);

    // Reset state, then ready right after release.
    step(1'b1, 1'b0, 0, 0, 0, 1, 64'h0, 2'b00);
    idle(1, 2'b00);

    // Single HT flit to own tile.
    step(1'b0, 1'b1, 0, 2, 1, 1, 64'h0000_0000_0000_a5a5, 2'b00);
    idle(4, 2'b00);

    // Four-flit packet heading west on VC1.
    step(1'b0, 1'b1, 1, 0, 1, 4, 64'h4444_3333_2222_1111, 2'b00);
    idle(6, 2'b00);

    // Stall on VC0 for cycles 2..4 after acceptance; VC1 bit toggles freely.
    step(1'b0, 1'b1, 0, 1, 1, 3, 64'h0000_cccc_bbbb_aaaa, 2'b00);
    for (int c = 1; c <= 10; c++) begin
      logic [1:0] oo;
      oo[0] = (c >= 2 && c <= 4);
      oo[1] = c[0];
      step(1'b0, 1'b0, 0, 0, 0, 1, 64'h0, oo);
    end

    // Back-to-back: len 2 east, then len 1 north held valid until taken.
    step(1'b0, 1'b1, 0, 3, 0, 2, 64'h0000_0000_beef_dead, 2'b00);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1, 2, 3, 1, 64'h0000_0000_0000_7777, 2'b00);
    idle(4, 2'b00);

    // Reset pulsed after two of four flits.
    step(1'b0, 1'b1, 1, 3, 2, 4, 64'hdddd_cccc_bbbb_aaaa, 2'b00);
    idle(2, 2'b00);
    step(1'b1, 1'b0, 0, 0, 0, 1, 64'h0, 2'b00);
    idle(6, 2'b00);

    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      logic [1:0] oo;
      oo[0] = ($urandom_range(0, 2) == 0);
      oo[1] = ($urandom_range(0, 2) == 0);
      step(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(1, MF)),
           {$urandom, $urandom}, oo);
    end
    idle(12, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
